mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4, width of the dwell-count input.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 dwell  input  DWELL_W  cycles to hold each select value; latched when start is accepted.
REQ-006 mux_in  input  2  2-bit data returned by the downstream 4:1 mux.
REQ-007 sel0  output  1  mux select LSB.
REQ-008 sel1  output  1  mux select MSB.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse on scan completion.
REQ-011 sample_valid  output  1  one-cycle pulse per captured sample.
REQ-012 sample_idx  output  2  select index of the current sample.
REQ-013 sample_data  output  2  captured mux_in value.
REQ-014 scan_word  output  8  packed result; bits [2k+1:2k] hold the sample for index k.

Function
REQ-015 The FSM SHALL have three states: IDLE, HOLD, and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch D_eff = max(dwell,1), set idx=0, load cnt=D_eff-1, clear scan_word, and enter HOLD.
REQ-017 {sel1,sel0} SHALL equal idx while in HOLD and SHALL be 2'b00 in IDLE and DONE; both are registered outputs.
REQ-018 In HOLD with cnt≠0, the block SHALL decrement cnt.
REQ-019 In HOLD with cnt=0, the block SHALL write mux_in into scan_word[2·idx+1:2·idx] and, in the next cycle, pulse sample_valid with sample_idx=idx and sample_data=mux_in.
REQ-020 After a capture with idx<3, the block SHALL increment idx, reload cnt=D_eff-1, and remain in HOLD.
REQ-021 After a capture with idx=3, the block SHALL enter DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-023 busy SHALL be 1 only in HOLD.
REQ-024 The block SHALL ignore start in HOLD and in DONE; a request is accepted only in IDLE, so start held high re-triggers on the first IDLE cycle after DONE.
REQ-025 Latency: with start accepted at edge E0, the done pulse SHALL follow edge E0+4·D_eff, and captures SHALL occur at edges E0+D_eff·(k+1) for k=0..3.
REQ-026 dwell changes during a scan SHALL have no effect.
REQ-027 scan_word SHALL hold its value from DONE until the next accepted start.

Reset
REQ-028 rst=1 SHALL force, at the next edge and regardless of state (including mid-scan), state=IDLE, idx=0, cnt=0, sel0=sel1=0, busy=0, done=0, sample_valid=0, sample_idx=0, sample_data=0, scan_word=0.
REQ-029 start SHALL be ignored in any cycle where rst=1.

Structure
REQ-030 Shared package mux_pkg SHALL hold the state enum (IDLE/HOLD/DONE), N_INPUTS=4, and DATA_W=2.
REQ-031 The dwell countdown SHALL be one sub-module, dwell_counter, with load, load value, decrement, and zero-flag outputs.

Verification
REQ-032 The bench SHALL connect the block to mux_gate with i0=00, i1=01, i2=10, i3=11, and verify a scan with dwell=1 -> captures on 4 consecutive edges, scan_word=8'hE4, done 4 cycles after accept.
REQ-033 dwell=3 -> sel holds each value for 3 cycles, sample_valid pulses 3 cycles apart with idx 0..3, done after 12 cycles, scan_word=8'hE4.
REQ-034 dwell=0 -> the block SHALL behave identically to dwell=1.
REQ-035 start pulsed again mid-scan -> no restart, done exactly once; start held high continuously -> back-to-back scans separated by one DONE cycle.
REQ-036 rst asserted at idx=2 -> all outputs 0 next cycle; a new start then completes a full scan with scan_word=8'hE4.
REQ-037 i2 changed to 00 before a scan -> scan_word=8'hC4.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and sizes for the mux scan controller.
//   state_t  - scan FSM states (IDLE, HOLD, DONE)
//   N_INPUTS - number of downstream mux inputs scanned per pass
//   DATA_W   - width of each mux input / captured sample
package mux_pkg;

    localparam int unsigned N_INPUTS = 4;
    localparam int unsigned DATA_W   = 2;
    localparam int unsigned IDX_W    = $clog2(N_INPUTS);
    localparam int unsigned WORD_W   = N_INPUTS * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_gate.sv
// mux_gate: combinational 4:1 mux driven by the scan controller's selects.
//   i0..i3     - data inputs
//   sel0, sel1 - select LSB / MSB
//   y_c        - selected input (combinational)
module mux_gate
    import mux_pkg::*;
(
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic              sel0,
    input  logic              sel1,
    output logic [DATA_W-1:0] y_c
);

    always_comb begin
        y_c = i0;
        case ({sel1, sel0})
            2'b00:   y_c = i0;
            2'b01:   y_c = i1;
            2'b10:   y_c = i2;
            default: y_c = i3;
        endcase
    end

endmodule

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// dwell_counter: loadable down-counter timing how long each select is held.
//   clk, rst  - clock, synchronous active-high reset (clears the count)
//   load      - load load_val (takes priority over dec)
//   load_val  - value to load
//   dec       - decrement when non-zero
//   zero_c    - count is zero (combinational)
module dwell_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through indices 0..3, holding each
// for a programmable dwell, captures the mux output at the end of each dwell
// and packs the four samples into scan_word.
//   clk, rst     - clock, synchronous active-high reset
//   start        - scan request (accepted only in IDLE)
//   dwell        - cycles per select value (0 treated as 1), latched on accept
//   mux_in       - data returned by the downstream mux
//   sel0, sel1   - registered mux select
//   busy         - scan in progress (HOLD)
//   done         - one-cycle completion pulse
//   sample_valid - one-cycle pulse per capture, with sample_idx/sample_data
//   scan_word    - packed samples, index k in bits [2k+1:2k]
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DATA_W-1:0]  mux_in,
    output logic               sel0,
    output logic               sel1,
    output logic               busy,
    output logic               done,
    output logic               sample_valid,
    output logic [IDX_W-1:0]   sample_idx,
    output logic [DATA_W-1:0]  sample_data,
    output logic [WORD_W-1:0]  scan_word
);

    state_t             state;
    logic [DWELL_W-1:0] d_eff;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   sel;

    logic [DWELL_W-1:0] dwell_eff_c;
    logic [DWELL_W-1:0] load_val_c;
    logic               accept_c;
    logic               capture_c;
    logic               last_c;
    logic               cnt_load_c;
    logic               cnt_dec_c;
    logic               cnt_zero_c;

    // A zero dwell behaves as a dwell of one.
    assign dwell_eff_c = (dwell == '0) ? DWELL_W'(1) : dwell;

    assign accept_c   = (state == IDLE) && start;
    assign capture_c  = (state == HOLD) && cnt_zero_c;
    assign last_c     = (idx == IDX_W'(N_INPUTS - 1));

    // Counter loads D_eff-1 on accept (from the live input) and on each
    // non-final capture (from the latched copy, so mid-scan dwell changes are ignored).
    assign cnt_load_c = accept_c || (capture_c && !last_c);
    assign cnt_dec_c  = (state == HOLD) && !cnt_zero_c;
    assign load_val_c = ((state == IDLE) ? dwell_eff_c : d_eff) - DWELL_W'(1);

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .load_val (load_val_c),
        .dec      (cnt_dec_c),
        .zero_c   (cnt_zero_c)
    );

    // Scan FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            d_eff        <= '0;
            idx          <= '0;
            sel          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            sample_data  <= '0;
            scan_word    <= '0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_eff     <= dwell_eff_c;
                        idx       <= '0;
                        sel       <= '0;
                        scan_word <= '0;
                        busy      <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero_c) begin
                        scan_word[{idx, 1'b0} +: DATA_W] <= mux_in;
                        sample_valid <= 1'b1;
                        sample_idx   <= idx;
                        sample_data  <= mux_in;
                        if (last_c) begin
                            idx   <= '0;
                            sel   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            sel <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sel0 = sel[0];
    assign sel1 = sel[1];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl driving a mux_gate.
// The driver predicts every sample and done event from the scan timing rules
// and queues them; a negedge monitor pops and compares them, and also checks
// select/busy/scan_word every cycle against a closed-form timeline.
module tb_mux_scan_ctrl;

    localparam int unsigned DW = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [1:0]    mux_in;
    logic          sel0, sel1, busy, done, sample_valid;
    logic [1:0]    sample_idx, sample_data;
    logic [7:0]    scan_word;
    logic [1:0]    i0 = 2'b00, i1 = 2'b01, i2 = 2'b10, i3 = 2'b11;

    mux_gate u_gate (
        .i0   (i0),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .sel0 (sel0),
        .sel1 (sel1),
        .y_c  (mux_in)
    );

    mux_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dwell        (dwell),
        .mux_in       (mux_in),
        .sel0         (sel0),
        .sel1         (sel1),
        .busy         (busy),
        .done         (done),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx),
        .sample_data  (sample_data),
        .scan_word    (scan_word)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; logic [1:0] idx; logic [1:0] data; } samp_t;
    typedef struct { int cyc; logic [7:0] word; } done_t;
    samp_t sq[$];
    done_t dq[$];

    // Reference model state: the current (or last) scan's start edge and dwell.
    bit         have_scan = 1'b0;
    int         c0        = 0;
    int         dd        = 1;
    int         next_free = 0;
    int         last_rst  = -1;
    logic [1:0] cur_i [4];

    // Drive one cycle of inputs and predict the effect of the coming edge.
    task automatic step(input logic r, input logic s, input logic [DW-1:0] dw, input bit rand_i);
        int         e;
        int         d;
        logic [7:0] word;
        @(negedge clk);
        #1;
        e = cyc + 1;
        if (rand_i && (!have_scan || e > c0 + 4 * dd) && ($urandom_range(0, 7) == 0)) begin
            case ($urandom_range(0, 3))
                0:       i0 = 2'($urandom);
                1:       i1 = 2'($urandom);
                2:       i2 = 2'($urandom);
                default: i3 = 2'($urandom);
            endcase
        end
        rst   = r;
        start = s;
        dwell = dw;
        if (r) begin
            sq.delete();
            dq.delete();
            have_scan = 1'b0;
            next_free = e + 1;
            last_rst  = e;
        end else if (s && e >= next_free) begin
            d         = (dw == '0) ? 1 : int'(dw);
            c0        = e;
            dd        = d;
            cur_i     = '{i0, i1, i2, i3};
            have_scan = 1'b1;
            next_free = e + 4 * d + 2;
            word      = '0;
            for (int k = 0; k < 4; k++) begin
                sq.push_back('{e + d * (k + 1), 2'(k), cur_i[k]});
                word |= 8'(cur_i[k]) << (2 * k);
            end
            dq.push_back('{e + 4 * d, word});
        end
    endtask

    always @(negedge clk) begin : mon
        int         off;
        logic [1:0] es;
        logic       eb;
        logic [7:0] ew;
        if (last_rst >= 0 && cyc >= last_rst) begin
            es = '0;
            eb = 1'b0;
            ew = '0;
            if (have_scan && cyc >= c0) begin
                off = cyc - c0;
                if (off < 4 * dd) begin
                    es = 2'(off / dd);
                    eb = 1'b1;
                end
                for (int k = 0; k < 4; k++)
                    if (cyc >= c0 + dd * (k + 1)) ew |= 8'(cur_i[k]) << (2 * k);
            end
            chk("sel", 32'({sel1, sel0}), 32'(es));
            chk("busy", 32'(busy), 32'(eb));
            chk("scan_word", 32'(scan_word), 32'(ew));
            if (cyc == last_rst) begin
                chk("rst_sample_idx", 32'(sample_idx), 32'(0));
                chk("rst_sample_data", 32'(sample_data), 32'(0));
            end
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                chk("sample_missing_cycle", 32'(cyc), 32'(sq[0].cyc));
                void'(sq.pop_front());
            end
            if (sample_valid !== 1'b0) begin
                if (sq.size() > 0 && sq[0].cyc == cyc) begin
                    chk("sample_idx", 32'(sample_idx), 32'(sq[0].idx));
                    chk("sample_data", 32'(sample_data), 32'(sq[0].data));
                    void'(sq.pop_front());
                end else begin
                    chk("sample_valid_unexpected", 32'(sample_valid), 32'(0));
                end
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("done_missing_cycle", 32'(cyc), 32'(dq[0].cyc));
                void'(dq.pop_front());
            end
            if (done !== 1'b0) begin
                if (dq.size() > 0 && dq[0].cyc == cyc) begin
                    chk("done_scan_word", 32'(scan_word), 32'(dq[0].word));
                    void'(dq.pop_front());
                end else begin
                    chk("done_unexpected", 32'(done), 32'(0));
                end
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);

        // dwell=1: four consecutive captures.
        step(1'b0, 1'b1, 4'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 4'($urandom), 1'b0);
        chk("word_dwell1", 32'(scan_word), 32'h0000_00E4);

        // dwell=3.
        step(1'b0, 1'b1, 4'd3, 1'b0);
        repeat (15) step(1'b0, 1'b0, 4'($urandom), 1'b0);
        chk("word_dwell3", 32'(scan_word), 32'h0000_00E4);

        // dwell=0 behaves as dwell=1.
        step(1'b0, 1'b1, 4'd0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 4'($urandom), 1'b0);
        chk("word_dwell0", 32'(scan_word), 32'h0000_00E4);

        // Mid-scan start pulses and dwell changes are ignored.
        step(1'b0, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, (i % 3) == 1, 4'd7, 1'b0);
        repeat (4) step(1'b0, 1'b0, 4'd0, 1'b0);
        chk("word_midscan_start", 32'(scan_word), 32'h0000_00E4);

        // start held high: back-to-back scans.
        repeat (20) step(1'b0, 1'b1, 4'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 4'd1, 1'b0);

        // Reset while idx=2, then a clean scan.
        step(1'b0, 1'b1, 4'd2, 1'b0);
        repeat (4) step(1'b0, 1'b0, 4'd2, 1'b0);
        step(1'b1, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 4'd2, 1'b0);
        chk("word_after_rst", 32'(scan_word), 32'h0000_0000);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 4'd1, 1'b0);
        chk("word_post_rst_scan", 32'(scan_word), 32'h0000_00E4);

        // i2 forced to 00.
        i2 = 2'b00;
        step(1'b0, 1'b1, 4'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 4'd1, 1'b0);
        chk("word_i2_zero", 32'(scan_word), 32'h0000_00C4);
        i2 = 2'b10;

        // Randomized traffic.
        repeat (3000)
            step(1'b1 && ($urandom_range(0, 299) == 0), $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 7)), 1'b1);

        repeat (40) step(1'b0, 1'b0, '0, 1'b0);
        chk("sample_queue_drained", 32'(sq.size()), 32'(0));
        chk("done_queue_drained", 32'(dq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
